banner_motion_ctrl: RTL
=======================

// Module: banner_motion_ctrl
// PURPOSE
//  Frame-paced motion controller for the win/lose banner sprite, generalising the fixed-X/Y mover.
//  On `show` it slides the banner in vertically, then bounces it horizontally between bounds
//  for a set number of reversals, then parks it and raises `done`.
//  Feeds topLeftX/topLeftY to the banner bitmap/draw block; paced by startOfFrame (SOF).
// PARAMETERS
//  FRAC_BITS      6    fixed-point fraction bits (1/64 px)
//  INITIAL_X      192  reset/idle X, px
//  INITIAL_Y      -64  reset/idle Y, px (off-screen above)
//  TARGET_Y       64   Y at end of slide-in, px
//  ENTER_Y_SPEED  256  slide-in speed, fixed-point units/frame (>0)
//  X_SPEED        128  bounce speed magnitude, fixed-point units/frame (>0)
//  LEFT_BOUND     192  min X during bounce, px
//  RIGHT_BOUND    383  max X during bounce, px (> LEFT_BOUND)
//  BOUNCE_COUNT   4    reversals before HOLD; 0 = bounce forever
//  BOB_AMPL       8    vertical bob amplitude, px (VERTICAL_BOB_EN only)
//  BOB_SPEED      64   vertical bob speed, fixed-point units/frame (VERTICAL_BOB_EN only)
// PORTS
//  clk           in   1   system clock
//  resetN        in   1   async active-low reset
//  startOfFrame  in   1   one-clk pulse per frame
//  show          in   1   level: 1 = run banner sequence, 0 = abort/return to idle
//  topLeftX      out  11  signed top-left X, px
//  topLeftY      out  11  signed top-left Y, px
//  moving        out  1   1 in ENTER or BOUNCE
//  done          out  1   1 in HOLD
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (resetN).
//  - Reset: state=IDLE; posX=INITIAL_X<<FRAC_BITS; posY=INITIAL_Y<<FRAC_BITS; xspeed=+X_SPEED;
//    bounce counter=0; moving=0; done=0.
//  - Positions and speeds are signed 32-bit. Outputs = pos >>> FRAC_BITS (arithmetic, floor),
//    truncated to 11 bits. All outputs are registered or decoded from registered state.
//  - States:
//    - IDLE: hold the initial position.
//      - show=1 -> ENTER on the next clk (not SOF-gated).
//      - First motion happens on the first SOF after entry.
//    - ENTER: on SOF, posY += ENTER_Y_SPEED.
//      - If the result >= TARGET_Y<<FRAC_BITS: clamp to the target, xspeed=+X_SPEED, counter=0,
//        go to BOUNCE.
//    - BOUNCE: on SOF, nx = posX + xspeed.
//      - nx >= RIGHT<<FRAC_BITS with xspeed>0: posX = RIGHT bound (clamp), xspeed=-X_SPEED, counter++.
//      - nx <= LEFT<<FRAC_BITS with xspeed<0: posX = LEFT bound (clamp), xspeed=+X_SPEED, counter++.
//      - Otherwise posX=nx.
//      - BOUNCE_COUNT!=0 and the counter reaches BOUNCE_COUNT on a reversal -> HOLD.
//        That reversal's clamped position stays.
//    - HOLD: freeze the position; done=1; stays until show=0.
//  - show=0 in any non-IDLE state -> IDLE on the next clk.
//    - Position and speed reload from the reset values; this is independent of SOF.
//    - show=0 has priority over a same-cycle SOF update.
//  - SOF in the same clk as the IDLE->ENTER transition: no motion that frame.
//  - Non-SOF clocks: no position change. Latency from SOF to the updated output is 1 clk.
//  - Counter saturates; with BOUNCE_COUNT=0, BOUNCE never exits except via show=0.
// CONFIGURATION
//  - VERTICAL_BOB_EN defined: in BOUNCE, on SOF, posY moves by ±BOB_SPEED.
//    - It reverses (with clamp) at TARGET_Y±BOB_AMPL; initial direction is up (negative).
//    - On entering HOLD, posY snaps to TARGET_Y.
//  - Undefined: posY fixed at TARGET_Y throughout BOUNCE and HOLD.
// TESTING
//  - Reset with defaults -> topLeftX=192, topLeftY=-64, moving=0, done=0; holds across 10 SOFs with show=0.
//  - show=1, then SOFs -> Y rises 4 px/SOF; topLeftY=64 and BOUNCE entered on SOF #32; moving=1.
//  - BOUNCE from X=192 -> +2 px/SOF; SOF #96 clamps X=383 and reverses; next SOF X=381.
//  - Run to the 4th reversal -> done=1, moving=0, X parked at 192 (left clamp); position frozen over 20 SOFs.
//  - show=0 mid-BOUNCE, same clk as SOF -> next clk X=192, Y=-64, IDLE, no extra step.
//  - VERTICAL_BOB_EN, BOB_AMPL=8, BOB_SPEED=64 -> Y steps 64,63,...,56 then reverses; snaps to 64 in HOLD.

Source files
------------

// File: rtl/banner_motion_ctrl.sv
// Frame-paced banner sprite mover: slide-in from above, horizontal bounce, then park.
// Optional feature macro: VERTICAL_BOB_EN (vertical bob while bouncing).
module banner_motion_ctrl #(
    parameter int FRAC_BITS     = 6,
    parameter int INITIAL_X     = 192,
    parameter int INITIAL_Y     = -64,
    parameter int TARGET_Y      = 64,
    parameter int ENTER_Y_SPEED = 256,
    parameter int X_SPEED       = 128,
    parameter int LEFT_BOUND    = 192,
    parameter int RIGHT_BOUND   = 383,
    parameter int BOUNCE_COUNT  = 4
`ifdef VERTICAL_BOB_EN
    ,
    parameter int BOB_AMPL      = 8,
    parameter int BOB_SPEED     = 64
`endif
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        show,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        moving,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // Handshake: none. show is a level sampled every clk; startOfFrame is a
    // one-clk strobe that paces all motion; outputs change one clk after it.

    localparam int ONE_PX    = 2 ** FRAC_BITS;
    localparam int INIT_X_FP = INITIAL_X * ONE_PX;
    localparam int INIT_Y_FP = INITIAL_Y * ONE_PX;
    localparam int TGT_Y_FP  = TARGET_Y * ONE_PX;
    localparam int LEFT_FP   = LEFT_BOUND * ONE_PX;
    localparam int RIGHT_FP  = RIGHT_BOUND * ONE_PX;
    localparam logic [15:0] BOUNCE_LIMIT = 16'(BOUNCE_COUNT);
`ifdef VERTICAL_BOB_EN
    localparam int BOB_TOP_FP = (TARGET_Y - BOB_AMPL) * ONE_PX;
    localparam int BOB_BOT_FP = (TARGET_Y + BOB_AMPL) * ONE_PX;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        BOUNCE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic signed [31:0] pos_x, pos_x_nxt;
    logic signed [31:0] pos_y, pos_y_nxt;
    logic signed [31:0] x_speed, x_speed_nxt;
    logic [15:0]        bounce_cnt, bounce_cnt_nxt;
`ifdef VERTICAL_BOB_EN
    logic               bob_up, bob_up_nxt;
    logic signed [31:0] bob_y;
`endif

    logic signed [31:0] step_x;
    logic signed [31:0] step_y;
    logic               hit_right;
    logic               hit_left;
    logic [15:0]        bounce_cnt_inc;
    logic               reach_hold;

    assign step_x         = pos_x + x_speed;
    assign step_y         = pos_y + ENTER_Y_SPEED;
    assign hit_right      = (x_speed > 0) && (step_x >= RIGHT_FP);
    assign hit_left       = (x_speed < 0) && (step_x <= LEFT_FP);
    assign bounce_cnt_inc = (bounce_cnt == 16'hFFFF) ? bounce_cnt : bounce_cnt + 16'd1;
    // A limit of 0 means bounce forever; the saturating counter never wraps back into range.
    assign reach_hold     = (BOUNCE_COUNT != 0) && (bounce_cnt_inc == BOUNCE_LIMIT);
`ifdef VERTICAL_BOB_EN
    assign bob_y          = bob_up ? (pos_y - BOB_SPEED) : (pos_y + BOB_SPEED);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            pos_x      <= INIT_X_FP;
            pos_y      <= INIT_Y_FP;
            x_speed    <= X_SPEED;
            bounce_cnt <= 16'd0;
`ifdef VERTICAL_BOB_EN
            bob_up     <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            pos_x      <= pos_x_nxt;
            pos_y      <= pos_y_nxt;
            x_speed    <= x_speed_nxt;
            bounce_cnt <= bounce_cnt_nxt;
`ifdef VERTICAL_BOB_EN
            bob_up     <= bob_up_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        pos_x_nxt      = pos_x;
        pos_y_nxt      = pos_y;
        x_speed_nxt    = x_speed;
        bounce_cnt_nxt = bounce_cnt;
`ifdef VERTICAL_BOB_EN
        bob_up_nxt     = bob_up;
`endif

        case (state)
            IDLE: begin
                // Entry is immediate; a coincident frame strobe produces no motion.
                if (show) begin
                    state_nxt = ENTER;
                end
            end

            ENTER: begin
                if (startOfFrame) begin
                    if (step_y >= TGT_Y_FP) begin
                        pos_y_nxt      = TGT_Y_FP;
                        x_speed_nxt    = X_SPEED;
                        bounce_cnt_nxt = 16'd0;
`ifdef VERTICAL_BOB_EN
                        bob_up_nxt     = 1'b1;
`endif
                        state_nxt      = BOUNCE;
                    end else begin
                        pos_y_nxt = step_y;
                    end
                end
            end

            BOUNCE: begin
                if (startOfFrame) begin
                    if (hit_right) begin
                        pos_x_nxt      = RIGHT_FP;
                        x_speed_nxt    = -X_SPEED;
                        bounce_cnt_nxt = bounce_cnt_inc;
                    end else if (hit_left) begin
                        pos_x_nxt      = LEFT_FP;
                        x_speed_nxt    = X_SPEED;
                        bounce_cnt_nxt = bounce_cnt_inc;
                    end else begin
                        pos_x_nxt = step_x;
                    end

`ifdef VERTICAL_BOB_EN
                    if (bob_up && (bob_y <= BOB_TOP_FP)) begin
                        pos_y_nxt  = BOB_TOP_FP;
                        bob_up_nxt = 1'b0;
                    end else if (!bob_up && (bob_y >= BOB_BOT_FP)) begin
                        pos_y_nxt  = BOB_BOT_FP;
                        bob_up_nxt = 1'b1;
                    end else begin
                        pos_y_nxt = bob_y;
                    end
`else
                    pos_y_nxt = TGT_Y_FP;
`endif

                    // The final reversal keeps its clamped X; Y parks on the target line.
                    if ((hit_right || hit_left) && reach_hold) begin
                        pos_y_nxt = TGT_Y_FP;
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                state_nxt = HOLD;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Dropping show wins over any same-cycle frame update.
        if ((state != IDLE) && !show) begin
            state_nxt      = IDLE;
            pos_x_nxt      = INIT_X_FP;
            pos_y_nxt      = INIT_Y_FP;
            x_speed_nxt    = X_SPEED;
            bounce_cnt_nxt = 16'd0;
`ifdef VERTICAL_BOB_EN
            bob_up_nxt     = 1'b1;
`endif
        end
    end

    assign topLeftX  = 11'(pos_x >>> FRAC_BITS);
    assign topLeftY  = 11'(pos_y >>> FRAC_BITS);
    assign moving    = (state == ENTER) || (state == BOUNCE);
    assign done      = (state == HOLD);
    assign dbg_state = state;

endmodule
